alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_seq_decode.sv | 68 ++++++
 rtl/alu_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction field positions, FSM encoding.
// Build option CARRY_CHAIN_EN enables the carry chain for ADC/SBB (see alu_seq_decode).
package alu_seq_pkg;

   localparam int INSTR_W = 16;
   localparam int DATA_W  = 16;
   localparam int REG_AW  = 3;
   localparam int IMM_W   = 5;
   localparam int OP_W    = 3;

   localparam int OP_LSB  = 13;
   localparam int RD_LSB  = 10;
   localparam int RA_LSB  = 7;
   localparam int RB_LSB  = 0;
   localparam int IMM_LSB = 0;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 3'b000,
      OP_ADC  = 3'b001,
      OP_SUB  = 3'b010,
      OP_SBB  = 3'b011,
      OP_ADDI = 3'b100,
      OP_SUBI = 3'b101,
      OP_CMP  = 3'b110,
      OP_NOP  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_e;

   function automatic op_e instr_op(input logic [INSTR_W-1:0] i);
      return op_e'(i[OP_LSB +: OP_W]);
   endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decode into ALU controls and write-back/flag enables.
// With CARRY_CHAIN_EN undefined, ADC runs as ADD and SBB as SUB with no carry-in.
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  op_e  op,
   output logic adc,
   output logic sub,
   output logic sbb,
   output logic src_alu_b,
   output logic wb_en,
   output logic flag_en,
   output logic carry_in_en
);

   always_comb begin
      adc         = 1'b0;
      sub         = 1'b0;
      sbb         = 1'b0;
      src_alu_b   = 1'b0;
      wb_en       = 1'b1;
      flag_en     = 1'b1;
      carry_in_en = 1'b0;
      case (op)
         OP_ADD: begin
         end
`ifdef CARRY_CHAIN_EN
         OP_ADC: begin
            adc         = 1'b1;
            carry_in_en = 1'b1;
         end
         OP_SBB: begin
            sbb         = 1'b1;
            carry_in_en = 1'b1;
         end
`else
         OP_ADC: begin
         end
         OP_SBB: begin
            sub = 1'b1;
         end
`endif
         OP_SUB: begin
            sub = 1'b1;
         end
         OP_ADDI: begin
            src_alu_b = 1'b1;
         end
         OP_SUBI: begin
            sub       = 1'b1;
            src_alu_b = 1'b1;
         end
         OP_CMP: begin
            sub   = 1'b1;
            wb_en = 1'b0;
         end
         OP_NOP: begin
            wb_en   = 1'b0;
            flag_en = 1'b0;
         end
         default: begin
            wb_en   = 1'b0;
            flag_en = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Three-cycle instruction sequencer driving an external RF and ALU (READ, EXEC, WB).
// Honours CARRY_CHAIN_EN through alu_seq_decode; default build has no ADC/SBB carry chain.
//
// state | meaning
// IDLE  | no instruction in flight, instr_ready high
// READ  | RF read addresses and ALU controls driven from latched instr
// EXEC  | ALU result settles; Write_Data and flags captured at end of cycle
// WB    | Write_En/done pulse; may accept the next instruction on the same edge
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   output logic [2:0]  Read_Addr_A,
   output logic [2:0]  Read_Addr_B,
   output logic [2:0]  Write_Addr,
   output logic [15:0] Write_Data,
   output logic        Write_En,
   output logic        ADC,
   output logic        SUB,
   output logic        SBB,
   output logic        Pre_C,
   output logic        Src_ALU_B,
   output logic [4:0]  imm5,
   input  logic [15:0] alu_Y,
   input  logic        alu_Z,
   input  logic        alu_N,
   input  logic        alu_C,
   input  logic        alu_V,
   output logic        flag_Z,
   output logic        flag_N,
   output logic        flag_C,
   output logic        flag_V,
   output logic        done,
   output logic        busy
);

   state_e              state_q;
   state_e              state_d;
   logic [INSTR_W-1:0]  instr_q;
   logic                accept;
   op_e                 op_q;

   logic dec_adc;
   logic dec_sub;
   logic dec_sbb;
   logic dec_src_b;
   logic dec_wb_en;
   logic dec_flag_en;
   logic dec_carry_in;

   // bits [6:5] are not part of any instruction field
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr_q[6:5];

   assign op_q = instr_op(instr_q);

   alu_seq_decode u_decode (
      .op          (op_q),
      .adc         (dec_adc),
      .sub         (dec_sub),
      .sbb         (dec_sbb),
      .src_alu_b   (dec_src_b),
      .wb_en       (dec_wb_en),
      .flag_en     (dec_flag_en),
      .carry_in_en (dec_carry_in)
   );

   assign instr_ready = !clr && ((state_q == ST_IDLE) || (state_q == ST_WB));
   assign accept      = instr_valid && instr_ready;
   assign busy        = (state_q != ST_IDLE);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_IDLE;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            instr_q <= instr;
         end
      end
   end

   // result and flags are registered so WB can drive them while the ALU inputs move on
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         Write_Data <= '0;
         flag_Z     <= 1'b0;
         flag_N     <= 1'b0;
         flag_C     <= 1'b0;
         flag_V     <= 1'b0;
      end else if (state_q == ST_EXEC) begin
         Write_Data <= alu_Y;
         if (dec_flag_en) begin
            flag_Z <= alu_Z;
            flag_N <= alu_N;
            flag_C <= alu_C;
            flag_V <= alu_V;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_READ;
         ST_READ: state_d = ST_EXEC;
         ST_EXEC: state_d = ST_WB;
         ST_WB:   state_d = accept ? ST_READ : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      Read_Addr_A = '0;
      Read_Addr_B = '0;
      imm5        = '0;
      Src_ALU_B   = 1'b0;
      ADC         = 1'b0;
      SUB         = 1'b0;
      SBB         = 1'b0;
      Pre_C       = 1'b0;
      Write_En    = 1'b0;
      Write_Addr  = '0;
      done        = 1'b0;
      case (state_q)
         ST_READ, ST_EXEC: begin
            Read_Addr_A = instr_q[RA_LSB +: REG_AW];
            Read_Addr_B = instr_q[RB_LSB +: REG_AW];
            imm5        = instr_q[IMM_LSB +: IMM_W];
            Src_ALU_B   = dec_src_b;
            ADC         = dec_adc;
            SUB         = dec_sub;
            SBB         = dec_sbb;
            Pre_C       = dec_carry_in && flag_C;
         end
         ST_WB: begin
            Write_En   = dec_wb_en;
            Write_Addr = instr_q[RD_LSB +: REG_AW];
            done       = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
